// File: rtl/pong_datapath.sv
`default_nettype none
// ============================================================================
// pong_datapath : paddle, ball and score datapath for a two-player Pong game.
// Revision      : 1.0
// ============================================================================
module pong_datapath #(
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_DX      = 2,
  parameter int BALL_DY      = 1,
  parameter int POINT_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       left_up,
  input  logic       left_down,
  input  logic       right_up,
  input  logic       right_down,
  output logic [9:0] leftPaddle,
  output logic [9:0] rightPaddle,
  output logic [9:0] ball_center_x,
  output logic [9:0] ball_center_y,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       game_over
);

  localparam logic [9:0] CENTER_X  = 10'd320;
  localparam logic [9:0] CENTER_Y  = 10'd220;
  localparam logic [9:0] PAD_HOME  = 10'd220;
  localparam logic [9:0] L_REBOUND = 10'd48;
  localparam logic [9:0] R_REBOUND = 10'd592;
  localparam logic [9:0] HIT_TOL   = 10'd29;

  // Limits already include paddle half-height / ball radius against the border.
  localparam logic signed [11:0] PAD_MIN = 12'sd46;
  localparam logic signed [11:0] PAD_MAX = 12'sd394;
  localparam logic signed [11:0] Y_MIN   = 12'sd25;
  localparam logic signed [11:0] Y_MAX   = 12'sd415;
  localparam logic signed [11:0] L_FACE  = 12'sd47;
  localparam logic signed [11:0] R_FACE  = 12'sd593;
  localparam logic signed [11:0] L_MISS  = 12'sd24;
  localparam logic signed [11:0] R_MISS  = 12'sd616;

  localparam logic signed [11:0] SPD = 12'(PADDLE_SPEED);
  localparam logic signed [11:0] DX  = 12'(BALL_DX);
  localparam logic signed [11:0] DY  = 12'(BALL_DY);

  localparam int               CNT_W    = (POINT_FRAMES > 1) ? $clog2(POINT_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    POINT    = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  state_t           state_q;
  logic [9:0]       lpad_q, rpad_q;
  logic [9:0]       bx_q, by_q;
  logic             dir_r_q, dir_d_q;
  logic [3:0]       lscore_q, rscore_q;
  logic [CNT_W-1:0] cnt_q;
  logic             over_q;

  logic [9:0]        lpad_d, rpad_d;
  logic [9:0]        bx_d, by_d;
  logic              dir_r_d, dir_d_d;
  logic signed [11:0] bx_s, cx, cy;
  logic              l_hit, r_hit, l_miss, r_miss;
  logic [3:0]        lscore_inc, rscore_inc;

  function automatic logic [9:0] paddle_step(input logic [9:0] pos, input logic up,
                                             input logic dn);
    logic signed [11:0] p;
    p = $signed({2'b00, pos});
    if (up && !dn) begin
      p = p - SPD;
    end else if (dn && !up) begin
      p = p + SPD;
    end
    if (p < PAD_MIN) begin
      p = PAD_MIN;
    end else if (p > PAD_MAX) begin
      p = PAD_MAX;
    end
    return 10'(p);
  endfunction

  function automatic logic near(input logic [9:0] a, input logic [9:0] b);
    return ((a > b) ? (a - b) : (b - a)) <= HIT_TOL;
  endfunction

  always_comb begin
    lpad_d = paddle_step(lpad_q, left_up, left_down);
    rpad_d = paddle_step(rpad_q, right_up, right_down);

    bx_s = $signed({2'b00, bx_q});
    cx   = bx_s + (dir_r_q ? DX : -DX);
    cy   = $signed({2'b00, by_q}) + (dir_d_q ? DY : -DY);

    by_d    = 10'(cy);
    dir_d_d = dir_d_q;
    if (cy < Y_MIN) begin
      by_d    = 10'(Y_MIN);
      dir_d_d = 1'b1;
    end else if (cy > Y_MAX) begin
      by_d    = 10'(Y_MAX);
      dir_d_d = 1'b0;
    end

    // Paddle tests use the ball row before this frame's vertical update.
    l_hit = !dir_r_q && (cx <= L_FACE) && (bx_s > L_FACE) && near(by_q, lpad_q);
    r_hit = dir_r_q && (cx >= R_FACE) && (bx_s < R_FACE) && near(by_q, rpad_q);

    bx_d    = 10'(cx);
    dir_r_d = dir_r_q;
    if (l_hit) begin
      bx_d    = L_REBOUND;
      dir_r_d = 1'b1;
    end else if (r_hit) begin
      bx_d    = R_REBOUND;
      dir_r_d = 1'b0;
    end

    l_miss     = !l_hit && (cx <= L_MISS);
    r_miss     = !r_hit && (cx >= R_MISS);
    lscore_inc = lscore_q + 4'd1;
    rscore_inc = rscore_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      lpad_q   <= PAD_HOME;
      rpad_q   <= PAD_HOME;
      bx_q     <= CENTER_X;
      by_q     <= CENTER_Y;
      dir_r_q  <= 1'b1;
      dir_d_q  <= 1'b1;
      lscore_q <= '0;
      rscore_q <= '0;
      cnt_q    <= '0;
      over_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= PLAY;
            dir_r_q <= 1'b1;
            dir_d_q <= 1'b1;
          end else if (frame_tick) begin
            lpad_q <= lpad_d;
            rpad_q <= rpad_d;
          end
        end

        PLAY: begin
          if (frame_tick) begin
            lpad_q <= lpad_d;
            rpad_q <= rpad_d;
            if (l_miss || r_miss) begin
              bx_q    <= CENTER_X;
              by_q    <= CENTER_Y;
              cnt_q   <= '0;
              // Serve toward the scorer: a left miss is a right point.
              dir_r_q <= l_miss;
              if (l_miss) begin
                rscore_q <= rscore_inc;
              end else begin
                lscore_q <= lscore_inc;
              end
              if ((l_miss && rscore_inc == WIN) || (r_miss && lscore_inc == WIN)) begin
                state_q <= GAMEOVER;
                over_q  <= 1'b1;
              end else begin
                state_q <= POINT;
              end
            end else begin
              bx_q    <= bx_d;
              by_q    <= by_d;
              dir_r_q <= dir_r_d;
              dir_d_q <= dir_d_d;
            end
          end
        end

        POINT: begin
          if (frame_tick) begin
            lpad_q <= lpad_d;
            rpad_q <= rpad_d;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= PLAY;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        GAMEOVER: begin
          if (start) begin
            state_q  <= PLAY;
            lscore_q <= '0;
            rscore_q <= '0;
            bx_q     <= CENTER_X;
            by_q     <= CENTER_Y;
            lpad_q   <= PAD_HOME;
            rpad_q   <= PAD_HOME;
            dir_r_q  <= 1'b1;
            over_q   <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign leftPaddle    = lpad_q;
  assign rightPaddle   = rpad_q;
  assign ball_center_x = bx_q;
  assign ball_center_y = by_q;
  assign left_score    = lscore_q;
  assign right_score   = rscore_q;
  assign game_over     = over_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_datapath.sv
`default_nettype none
// ============================================================================
// tb_pong_datapath : directed scoreboard bench for pong_datapath.
// Revision         : 1.0
// ============================================================================
module tb_pong_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       left_up = 1'b0, left_down = 1'b0, right_up = 1'b0, right_down = 1'b0;
  logic [9:0] leftPaddle, rightPaddle, ball_center_x, ball_center_y;
  logic [3:0] left_score, right_score;
  logic       game_over;

  pong_datapath dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .left_up      (left_up),
    .left_down    (left_down),
    .right_up     (right_up),
    .right_down   (right_down),
    .leftPaddle   (leftPaddle),
    .rightPaddle  (rightPaddle),
    .ball_center_x(ball_center_x),
    .ball_center_y(ball_center_y),
    .left_score   (left_score),
    .right_score  (right_score),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] M_LP = 7'h01, M_RP = 7'h02, M_BX = 7'h04, M_BY = 7'h08;
  localparam logic [6:0] M_LS = 7'h10, M_RS = 7'h20, M_GO = 7'h40, ALL = 7'h7f;
  localparam logic [3:0] B_LU = 4'b1000, B_LD = 4'b0100, B_RU = 4'b0010, B_RD = 4'b0001;

  typedef struct {
    int         cyc;
    string      name;
    logic [6:0] mask;
    logic [9:0] lp, rp, bx, by;
    logic [3:0] ls, rs;
    logic       go;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation due by this cycle, away from the edge.
  always @(negedge clk) begin
    #2;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic bad;
      e   = sb.pop_front();
      bad = (e.mask[0] && leftPaddle    !== e.lp) || (e.mask[1] && rightPaddle   !== e.rp) ||
            (e.mask[2] && ball_center_x !== e.bx) || (e.mask[3] && ball_center_y !== e.by) ||
            (e.mask[4] && left_score    !== e.ls) || (e.mask[5] && right_score   !== e.rs) ||
            (e.mask[6] && game_over     !== e.go);
      n_vec++;
      if (bad) begin
        n_bad++;
        $display("FAIL %s @cyc %0d (mask %h): got lp=%0d rp=%0d x=%0d y=%0d ls=%0d rs=%0d go=%0d, want lp=%0d rp=%0d x=%0d y=%0d ls=%0d rs=%0d go=%0d",
                 e.name, cyc, e.mask, leftPaddle, rightPaddle, ball_center_x, ball_center_y,
                 left_score, right_score, game_over, e.lp, e.rp, e.bx, e.by, e.ls, e.rs, e.go);
      end
    end
  end

  task automatic expect_v(input string name, input logic [6:0] mask, input int lp, input int rp,
                          input int bx, input int by, input int ls, input int rs, input int go);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.mask = mask;
    e.lp   = 10'(lp);
    e.rp   = 10'(rp);
    e.bx   = 10'(bx);
    e.by   = 10'(by);
    e.ls   = 4'(ls);
    e.rs   = 4'(rs);
    e.go   = (go != 0);
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge after one active edge.
  task automatic step(input logic ft, input logic st, input logic rst, input logic [3:0] btn);
    frame_tick = ft;
    start      = st;
    reset      = rst;
    {left_up, left_down, right_up, right_down} = btn;
    @(negedge clk);
    frame_tick = 1'b0;
    start      = 1'b0;
    reset      = 1'b0;
    {left_up, left_down, right_up, right_down} = 4'b0000;
  endtask

  task automatic ticks(input int n, input logic [3:0] btn);
    repeat (n) step(1'b1, 1'b0, 1'b0, btn);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ltarget;
    int         next_pt;
    int         k;
    logic [9:0] px;
    logic [3:0] btn;

    @(negedge clk);

    // Reset wins over frame_tick/start/buttons; IDLE ticks hold everything.
    step(1'b1, 1'b1, 1'b1, B_LU | B_RD);
    step(1'b1, 1'b1, 1'b1, 4'b0000);
    expect_v("reset", ALL, 220, 220, 320, 220, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      ticks(1, 4'b0000);
      expect_v("idle_tick", ALL, 220, 220, 320, 220, 0, 0, 0);
    end

    // Paddle motion and clamping in IDLE.
    ticks(5, B_LU);
    expect_v("lpad_up5", ALL, 200, 220, 320, 220, 0, 0, 0);
    ticks(5, B_LU);
    expect_v("lpad_up10", ALL, 180, 220, 320, 220, 0, 0, 0);
    ticks(50, B_LU);
    expect_v("lpad_clamp_top", ALL, 46, 220, 320, 220, 0, 0, 0);
    ticks(3, B_LU | B_LD);
    expect_v("lpad_both", ALL, 46, 220, 320, 220, 0, 0, 0);
    ticks(1, B_LD);
    expect_v("lpad_down1", ALL, 50, 220, 320, 220, 0, 0, 0);
    ticks(43, B_RD);
    expect_v("rpad_down43", ALL, 50, 392, 320, 220, 0, 0, 0);
    ticks(1, B_RD);
    expect_v("rpad_clamp_bot", ALL, 50, 394, 320, 220, 0, 0, 0);

    // Serve, right-paddle return and bottom bounce.
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    expect_v("reset2", ALL, 220, 220, 320, 220, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 4'b0000);
    expect_v("start_tick_no_move", ALL, 220, 220, 320, 220, 0, 0, 0);
    ticks(1, B_RD);
    expect_v("first_move", ALL, 220, 224, 322, 221, 0, 0, 0);
    ticks(33, B_RD);
    expect_v("tick34", ALL, 220, 356, 388, 254, 0, 0, 0);
    ticks(15, 4'b0000);
    step(1'b1, 1'b1, 1'b0, 4'b0000);
    expect_v("start_ignored_play", ALL, 220, 356, 420, 270, 0, 0, 0);
    ticks(87, 4'b0000);
    expect_v("right_hit", ALL, 220, 356, 592, 357, 0, 0, 0);
    ticks(1, 4'b0000);
    expect_v("after_hit", ALL, 220, 356, 590, 358, 0, 0, 0);
    ticks(57, 4'b0000);
    expect_v("y_at_max", ALL, 220, 356, 476, 415, 0, 0, 0);
    ticks(1, 4'b0000);
    expect_v("y_bounce", ALL, 220, 356, 474, 415, 0, 0, 0);
    ticks(1, 4'b0000);
    expect_v("y_up", ALL, 220, 356, 472, 414, 0, 0, 0);

    // Right paddle parked at top: left scores, POINT hold, serve left.
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 4'b0000);
    expect_v("start_no_tick", ALL, 220, 220, 320, 220, 0, 0, 0);
    ticks(43, B_RU);
    expect_v("rpad_up43", ALL, 220, 48, 406, 263, 0, 0, 0);
    ticks(1, B_RU);
    expect_v("rpad_clamp_top", ALL, 220, 46, 408, 264, 0, 0, 0);
    ticks(103, 4'b0000);
    expect_v("before_miss", ALL, 220, 46, 614, 367, 0, 0, 0);
    ticks(1, 4'b0000);
    expect_v("left_point", ALL, 220, 46, 320, 220, 1, 0, 0);
    ticks(21, 4'b0000);
    step(1'b1, 1'b1, 1'b0, 4'b0000);
    expect_v("start_ignored_point", ALL, 220, 46, 320, 220, 1, 0, 0);
    ticks(38, 4'b0000);
    expect_v("point_hold_end", ALL, 220, 46, 320, 220, 1, 0, 0);
    ticks(1, 4'b0000);
    expect_v("serve_left", ALL, 220, 46, 318, 221, 1, 0, 0);
    ticks(1, 4'b0000);
    expect_v("serve_left2", ALL, 220, 46, 316, 222, 1, 0, 0);

    // Nine right points: right paddle tracks the ball, left paddle steers clear.
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 4'b0000);
    ltarget = 220;
    px      = 10'd320;
    next_pt = 421;
    k       = 1;
    for (int t = 1; t <= 4269; t++) begin
      if (ball_center_x == 10'd248 && px == 10'd250)
        ltarget = (ball_center_y < 10'd220) ? 394 : 46;
      px  = ball_center_x;
      btn = {(int'(leftPaddle) > ltarget), (int'(leftPaddle) < ltarget),
             (rightPaddle > ball_center_y), (rightPaddle < ball_center_y)};
      step(1'b1, 1'b0, 1'b0, btn);
      if (t == next_pt) begin
        expect_v("right_point", M_BX | M_BY | M_LS | M_RS | M_GO, 0, 0, 320, 220, 0, k,
                 (k == 9) ? 1 : 0);
        k++;
        next_pt += 481;
      end
    end
    ticks(5, B_LU | B_RU);
    expect_v("gameover_frozen", M_BX | M_BY | M_LS | M_RS | M_GO, 0, 0, 320, 220, 0, 9, 1);
    step(1'b0, 1'b1, 1'b0, 4'b0000);
    expect_v("restart", ALL, 220, 220, 320, 220, 0, 0, 0);
    ticks(5, 4'b0000);
    expect_v("restart_serve_right", ALL & ~M_BY, 220, 220, 330, 0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b1, B_LU);
    expect_v("reset_mid_play", ALL, 220, 220, 320, 220, 0, 0, 0);

    step(1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left uncompared, want 0", sb.size());
      n_bad += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
